inst_encoder_loader: RTL
========================

// Module: inst_encoder_loader
// PURPOSE
//  Encodes field-level instruction requests into 16-bit SIMPLE instruction words.
//  Streams them into instruction memory at consecutive addresses.
//  Inverse of the pipeline control decoder: every word it emits decodes back to the requested fields.
//  Sits between the debug/boot host interface and the imem write port.
// PARAMETERS
//  ADDR_W  8   imem address width; DEPTH = 2**ADDR_W words
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       pulse: begin load session at base_addr
//  base_addr    in   ADDR_W  first write address, sampled on start
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when req_valid && req_ready
//  req_fmt      in   2       major class -> inst[15:14] (00 LD, 01 ST, 10 imm/branch, 11 ALU/IO)
//  req_op       in   4       fmt 11: op -> inst[7:4]; fmt 10: op[2:0] -> inst[13:11]
//  req_ra       in   3       fmt 00/01/11 -> inst[13:11]
//  req_rb       in   3       inst[10:8] (Rd/Rb; branch condition for fmt 10 op 111)
//  req_imm      in   8       fmt 00/01/10 -> inst[7:0]; fmt 11 -> imm[3:0] -> inst[3:0]
//  imem_we      out  1       imem write strobe
//  imem_addr    out  ADDR_W  imem write address
//  imem_wdata   out  16      encoded instruction
//  busy         out  1       session active
//  done         out  1       sticky: HALT word written, cleared by start
//  err          out  1       sticky: reserved encoding or address overflow, cleared by start
//  word_count   out  ADDR_W+1  words written this session
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0.
//  FSM states: IDLE, RUN, DRAIN, STOP.
//   - IDLE --start--> RUN. start loads wptr=base_addr and clears done/err/word_count.
//   - RUN --HALT accepted or error--> DRAIN --1 cycle--> STOP.
//   - STOP --start--> RUN.
//   - start in RUN/DRAIN is ignored.
//  req_ready = (state==RUN) && !ovf_pend; combinational from registered state only.
//  Accept cycle N: encoded word is registered; imem_we=1 in cycle N+1 with imem_addr=wptr; wptr++ and word_count++ at N+1.
//  Latency is exactly 1 cycle. Back-to-back accepts give one write per cycle.
//  Encoding is pure concatenation, with no arithmetic on fields:
//   - fmt 11: {11,ra,rb,op,imm[3:0]}
//   - fmt 00/01: {fmt,ra,rb,imm}
//   - fmt 10: {10,op[2:0],rb,imm}
//  Reserved requests:
//   - fmt 11 op 0111 or 1110
//   - fmt 10 op[2:0] 110
//   - fmt 10 op[3]=1
//  A reserved request is accepted but not written (imem_we stays 0); it sets err and the FSM goes to DRAIN.
//  HALT (fmt 11 op 1111) is written normally, then sets done and the FSM goes to DRAIN.
//  Overflow: a write at wptr = DEPTH-1 completes; the address never wraps.
//   - ovf_pend is then set and req_ready drops.
//   - The next accepted-would-be request is not taken; err is set and the FSM goes to DRAIN.
//  Simultaneous HALT and last-address write: done=1, err=0.
//  busy = (state==RUN || state==DRAIN).
//  rst_n low mid-session: immediate abort, in-flight write dropped, all outputs 0.
// STRUCTURE
//  Shared package: FMT_* (2-bit), ALU_OP_* (4-bit incl. OP_HALT=4'b1111, OP_IN=1100, OP_OUT=1101), BR_OP_* (3-bit: LI 000, B 100, BCC 111, SLI 101, CMPI 011), state encodings.
//  The decoder uses the same package constants.
//  One sub-module, inst_field_encoder: combinational {fmt,op,ra,rb,imm} -> {word,reserved}.
// TESTING
//  - start base 0x10; ADD fmt11 op0000 ra=1 rb=2 -> cycle+1 we=1, addr 0x10, wdata 16'hCA00.
//  - LD ra=3 rb=4 imm=0x2A, then ST, back-to-back -> wdata 16'h1C2A then 0x5C2A-class words at 0x00,0x01, one per cycle.
//  - BCC fmt10 op0111 rb=001 imm=0xFE -> wdata 16'hB9FE; then HALT -> wdata 16'hC0F0, done=1, busy=0 after DRAIN.
//  - fmt11 op0111 -> no write, err=1, done=0, word_count unchanged.
//  - base_addr=DEPTH-1, two requests -> one write at DEPTH-1, req_ready=0, err=1, no write at addr 0.
//  - rst_n asserted while req accepted -> no imem_we next cycle; all outputs 0; fresh start works.

Source files
------------

// File: rtl/inst_encoder_loader_pkg.sv
// Shared constants for the SIMPLE 16-bit instruction set: format classes,
// opcodes and the loader FSM states. The pipeline decoder uses the same names.
package inst_encoder_loader_pkg;

  localparam logic [1:0] FMT_LD  = 2'b00;
  localparam logic [1:0] FMT_ST  = 2'b01;
  localparam logic [1:0] FMT_IMM = 2'b10;
  localparam logic [1:0] FMT_ALU = 2'b11;

  localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OP_RSV_A = 4'b0111;
  localparam logic [3:0] ALU_OP_RSV_B = 4'b1110;
  localparam logic [3:0] OP_IN        = 4'b1100;
  localparam logic [3:0] OP_OUT       = 4'b1101;
  localparam logic [3:0] OP_HALT      = 4'b1111;

  localparam logic [2:0] BR_OP_LI   = 3'b000;
  localparam logic [2:0] BR_OP_CMPI = 3'b011;
  localparam logic [2:0] BR_OP_B    = 3'b100;
  localparam logic [2:0] BR_OP_SLI  = 3'b101;
  localparam logic [2:0] BR_OP_RSV  = 3'b110;
  localparam logic [2:0] BR_OP_BCC  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] fmt;
    logic [3:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] imm;
  } req_t;

  function automatic logic is_halt(input req_t r);
    return (r.fmt == FMT_ALU) && (r.op == OP_HALT);
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Host request handshake plus the imem write port of the loader.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_fmt;
  logic [3:0]        req_op;
  logic [2:0]        req_ra;
  logic [2:0]        req_rb;
  logic [7:0]        req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output req_valid, req_fmt, req_op, req_ra, req_rb, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_fmt, req_op, req_ra, req_rb, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader_field_encoder.sv
// Combinational field packer: request fields -> 16-bit instruction word,
// flagging encodings the decoder treats as reserved.
module inst_field_encoder
  import inst_encoder_loader_pkg::*;
(
  input  req_t        req,
  output logic [15:0] word,
  output logic        reserved
);
  always_comb begin
    word     = {req.fmt, req.ra, req.rb, req.imm};
    reserved = 1'b0;
    case (req.fmt)
      FMT_ALU: begin
        word     = {FMT_ALU, req.ra, req.rb, req.op, req.imm[3:0]};
        reserved = (req.op == ALU_OP_RSV_A) || (req.op == ALU_OP_RSV_B);
      end
      FMT_IMM: begin
        // ra is not encoded here: the op field occupies its slot
        word     = {FMT_IMM, req.op[2:0], req.rb, req.imm};
        reserved = req.op[3] || (req.op[2:0] == BR_OP_RSV);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/inst_encoder_loader.sv
// Boot/debug loader: encodes accepted requests and streams them into imem at
// consecutive addresses, one cycle after acceptance.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  inst_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      word_count
);
  localparam logic [ADDR_W-1:0] LAST    = '1;
  localparam logic [ADDR_W-1:0] LAST_M1 = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              done_reg, err_reg, ovf_reg;
  logic              we_reg, halt_wr_reg;
  logic [15:0]       wdata_reg;

  req_t        req;
  logic [15:0] word;
  logic        reserved, accept, halt, take, target_last, launch, ovf_hit;

  assign req = {bus.req_fmt, bus.req_op, bus.req_ra, bus.req_rb, bus.req_imm};

  inst_field_encoder u_enc (
    .req      (req),
    .word     (word),
    .reserved (reserved)
  );

  assign bus.req_ready = (state_reg == ST_RUN) && !ovf_reg;
  assign accept        = bus.req_valid && bus.req_ready;
  assign halt          = is_halt(req);
  assign take          = accept && !reserved;
  assign launch        = start && ((state_reg == ST_IDLE) || (state_reg == ST_STOP));
  assign ovf_hit       = (state_reg == ST_RUN) && ovf_reg && bus.req_valid;
  // A word accepted now lands one slot further on if a write is already in flight
  assign target_last   = we_reg ? (wptr_reg == LAST_M1) : (wptr_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_STOP: if (start) state_next = ST_RUN;
      ST_RUN:   if ((accept && (reserved || halt)) || ovf_hit) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_STOP;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      wptr_reg    <= '0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      ovf_reg     <= 1'b0;
      we_reg      <= 1'b0;
      halt_wr_reg <= 1'b0;
      wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      we_reg      <= take;
      halt_wr_reg <= take && halt;
      if (take) wdata_reg <= word;
      if (launch) begin
        wptr_reg  <= base_addr;
        count_reg <= '0;
        done_reg  <= 1'b0;
        err_reg   <= 1'b0;
        ovf_reg   <= 1'b0;
      end else begin
        if (we_reg) begin
          if (wptr_reg != LAST) wptr_reg <= wptr_reg + 1'b1;
          count_reg <= count_reg + 1'b1;
        end
        if (halt_wr_reg) done_reg <= 1'b1;
        if (take && target_last) ovf_reg <= 1'b1;
        if ((accept && reserved) || ovf_hit) err_reg <= 1'b1;
      end
    end
  end

  assign bus.imem_we    = we_reg;
  assign bus.imem_addr  = wptr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done           = done_reg;
  assign err            = err_reg;
  assign word_count     = count_reg;
endmodule
